conv2d_seq_engine: RTL and testbench

Sequential, parametrised successor to the single-cycle convolution block. It computes a batched 2-D convolution with one multiply-accumulate per clock instead of a fully unrolled datapath. It snapshots its operands on a `start` handshake and streams results over a valid/ready port. It sits between the tensor buffers and the next layer stage, adding signed saturation, optional ReLU and output backpressure.

---
 rtl/conv2d_seq_engine.sv | 223 ++++++++++++++++++++++
 tb/tb_conv2d_seq_engine.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_seq_engine.sv
// conv2d_seq_engine: batched 2-D convolution, one multiply-accumulate per clock.
// Operands are snapshotted on start; results stream out over valid/ready with
// signed saturation and optional ReLU.
module conv2d_seq_engine #(
    parameter int BATCH_SIZE   = 1,
    parameter int IN_CHANNELS  = 2,
    parameter int OUT_CHANNELS = 2,
    parameter int IN_HEIGHT    = 4,
    parameter int IN_WIDTH     = 4,
    parameter int KERNEL_SIZE  = 2,
    parameter int STRIDE       = 2,
    parameter int PADDING      = 0,
    parameter int DATA_WIDTH   = 16,
    parameter int ACC_WIDTH    = 40,
    localparam int OUT_HEIGHT  = (IN_HEIGHT + 2*PADDING - KERNEL_SIZE)/STRIDE + 1,
    localparam int OUT_WIDTH   = (IN_WIDTH + 2*PADDING - KERNEL_SIZE)/STRIDE + 1,
    localparam int N_TAPS      = IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE,
    localparam int N_OUT       = BATCH_SIZE*OUT_CHANNELS*OUT_HEIGHT*OUT_WIDTH,
    localparam int IDX_W       = (N_OUT > 1) ? $clog2(N_OUT) : 1,
    localparam int IN_BITS     = BATCH_SIZE*IN_CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH,
    localparam int W_BITS      = OUT_CHANNELS*N_TAPS*DATA_WIDTH,
    localparam int B_BITS      = OUT_CHANNELS*DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  relu_en,
    input  logic [IN_BITS-1:0]    input_tensor_flat,
    input  logic [W_BITS-1:0]     weights_flat,
    input  logic [B_BITS-1:0]     bias_flat,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [IDX_W-1:0]      out_index,
    output logic                  done
);
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BW       = cw(BATCH_SIZE);
    localparam int OCW      = cw(OUT_CHANNELS);
    localparam int OHW      = cw(OUT_HEIGHT);
    localparam int OWW      = cw(OUT_WIDTH);
    localparam int ICW      = cw(IN_CHANNELS);
    localparam int KSW      = cw(KERNEL_SIZE);
    localparam int IN_OFF_W = cw(IN_BITS);
    localparam int W_OFF_W  = cw(W_BITS);
    localparam int B_OFF_W  = cw(B_BITS);
    localparam int PROD_W   = 2*DATA_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, EMIT, DONE} state_t;
    state_t state_q, state_d;

    logic [IN_BITS-1:0]          in_snap;
    logic [W_BITS-1:0]           w_snap;
    logic [B_BITS-1:0]           b_snap;
    logic                        relu_q;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_sum;
    logic [BW-1:0]               b_q, b_n;
    logic [OCW-1:0]              oc_q, oc_n;
    logic [OHW-1:0]              oh_q, oh_n;
    logic [OWW-1:0]              ow_q, ow_n;
    logic [ICW-1:0]              ic_q;
    logic [KSW-1:0]              kh_q, kw_q;
    logic [IDX_W-1:0]            idx_q;

    int                          ih, iw, in_addr, w_addr;
    logic                        in_bounds;
    logic signed [DATA_WIDTH-1:0] in_elem, w_elem, bias_next;
    logic signed [PROD_W-1:0]    prod;
    logic                        tap_last, out_last, hs;

    assign tap_last  = (ic_q == ICW'(IN_CHANNELS-1)) && (kh_q == KSW'(KERNEL_SIZE-1)) &&
                       (kw_q == KSW'(KERNEL_SIZE-1));
    assign out_last  = (idx_q == IDX_W'(N_OUT-1));
    assign hs        = out_valid && out_ready;
    assign out_index = idx_q;

    // Saturate the accumulator to the output width, then apply ReLU if enabled.
    function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] a,
                                                  input logic relu);
        logic [DATA_WIDTH-1:0] r;
        if (a > SAT_MAX)      r = SAT_MAX[DATA_WIDTH-1:0];
        else if (a < SAT_MIN) r = SAT_MIN[DATA_WIDTH-1:0];
        else                  r = a[DATA_WIDTH-1:0];
        if (relu && r[DATA_WIDTH-1]) r = '0;
        return r;
    endfunction

    // Current tap: operand fetch (zero outside the image) and accumulate.
    always_comb begin
        ih        = int'(oh_q)*STRIDE + int'(kh_q) - PADDING;
        iw        = int'(ow_q)*STRIDE + int'(kw_q) - PADDING;
        in_bounds = (ih >= 0) && (ih < IN_HEIGHT) && (iw >= 0) && (iw < IN_WIDTH);
        in_addr   = 0;
        if (in_bounds)
            in_addr = ((int'(b_q)*IN_CHANNELS + int'(ic_q))*IN_HEIGHT + ih)*IN_WIDTH + iw;
        w_addr    = ((int'(oc_q)*IN_CHANNELS + int'(ic_q))*KERNEL_SIZE + int'(kh_q))*KERNEL_SIZE
                    + int'(kw_q);
        in_elem   = in_bounds ? in_snap[IN_OFF_W'(in_addr*DATA_WIDTH) +: DATA_WIDTH] : '0;
        w_elem    = w_snap[W_OFF_W'(w_addr*DATA_WIDTH) +: DATA_WIDTH];
        prod      = in_elem * w_elem;
        acc_sum   = acc_q + {{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};
    end

    // Next output coordinates (ow fastest) and the bias of that output's channel.
    always_comb begin
        ow_n = ow_q + 1'b1;
        oh_n = oh_q;
        oc_n = oc_q;
        b_n  = b_q;
        if (ow_q == OWW'(OUT_WIDTH-1)) begin
            ow_n = '0;
            oh_n = oh_q + 1'b1;
            if (oh_q == OHW'(OUT_HEIGHT-1)) begin
                oh_n = '0;
                oc_n = oc_q + 1'b1;
                if (oc_q == OCW'(OUT_CHANNELS-1)) begin
                    oc_n = '0;
                    b_n  = b_q + 1'b1;
                end
            end
        end
        bias_next = b_snap[B_OFF_W'(int'(oc_n)*DATA_WIDTH) +: DATA_WIDTH];
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = MAC;
            MAC:     if (tap_last) state_d = EMIT;
            EMIT:    if (hs) state_d = out_last ? DONE : MAC;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; status outputs are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy      <= (state_d != IDLE);
            out_valid <= (state_d == EMIT);
            done      <= (state_d == DONE);
        end
    end

    // Datapath: snapshot, tap walk, accumulate, result capture, output advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_snap  <= '0;
            w_snap   <= '0;
            b_snap   <= '0;
            relu_q   <= 1'b0;
            acc_q    <= '0;
            b_q      <= '0;
            oc_q     <= '0;
            oh_q     <= '0;
            ow_q     <= '0;
            ic_q     <= '0;
            kh_q     <= '0;
            kw_q     <= '0;
            idx_q    <= '0;
            out_data <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    in_snap <= input_tensor_flat;
                    w_snap  <= weights_flat;
                    b_snap  <= bias_flat;
                    relu_q  <= relu_en;
                    acc_q   <= {{(ACC_WIDTH-DATA_WIDTH){bias_flat[DATA_WIDTH-1]}},
                                bias_flat[DATA_WIDTH-1:0]};
                    b_q     <= '0;
                    oc_q    <= '0;
                    oh_q    <= '0;
                    ow_q    <= '0;
                    ic_q    <= '0;
                    kh_q    <= '0;
                    kw_q    <= '0;
                    idx_q   <= '0;
                end
                MAC: begin
                    acc_q <= acc_sum;
                    if (kw_q == KSW'(KERNEL_SIZE-1)) begin
                        kw_q <= '0;
                        if (kh_q == KSW'(KERNEL_SIZE-1)) begin
                            kh_q <= '0;
                            ic_q <= (ic_q == ICW'(IN_CHANNELS-1)) ? '0 : ic_q + 1'b1;
                        end else begin
                            kh_q <= kh_q + 1'b1;
                        end
                    end else begin
                        kw_q <= kw_q + 1'b1;
                    end
                    if (tap_last) out_data <= sat(acc_sum, relu_q);
                end
                EMIT: if (hs && !out_last) begin
                    ow_q  <= ow_n;
                    oh_q  <= oh_n;
                    oc_q  <= oc_n;
                    b_q   <= b_n;
                    idx_q <= idx_q + 1'b1;
                    acc_q <= {{(ACC_WIDTH-DATA_WIDTH){bias_next[DATA_WIDTH-1]}}, bias_next};
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_conv2d_seq_engine.sv
// Directed bench for conv2d_seq_engine: default-geometry runs plus a padded
// 3x3 instance, all compared against hand-computed values.
module tb_conv2d_seq_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic         start = 1'b0, relu_en = 1'b0, out_ready = 1'b1;
    logic [511:0] in_flat = '0;
    logic [255:0] wt_flat = '0;
    logic [31:0]  b_flat = '0;
    logic         busy, out_valid, done;
    logic [15:0]  out_data;
    logic [2:0]   out_index;

    logic         start_p = 1'b0;
    logic [255:0] in_p = '0;
    logic [143:0] wt_p = '0;
    logic [15:0]  b_p = '0;
    logic         busy_p, ov_p, done_p;
    logic [15:0]  od_p;
    logic [3:0]   oi_p;

    int          n_chk = 0, n_err = 0;
    logic [15:0] exp_d [8];

    conv2d_seq_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .relu_en(relu_en),
        .input_tensor_flat(in_flat), .weights_flat(wt_flat), .bias_flat(b_flat),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .done(done)
    );

    conv2d_seq_engine #(.IN_CHANNELS(1), .OUT_CHANNELS(1), .KERNEL_SIZE(3),
                        .STRIDE(1), .PADDING(1)) dut_p (
        .clk(clk), .rst_n(rst_n), .start(start_p), .relu_en(1'b0),
        .input_tensor_flat(in_p), .weights_flat(wt_p), .bias_flat(b_p),
        .busy(busy_p), .out_valid(ov_p), .out_ready(1'b1),
        .out_data(od_p), .out_index(oi_p), .done(done_p)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic fill(input logic [15:0] iv, input logic [15:0] wv,
                        input logic [15:0] b0, input logic [15:0] b1);
        for (int i = 0; i < 32; i++) in_flat[i*16 +: 16] = iv;
        for (int i = 0; i < 16; i++) wt_flat[i*16 +: 16] = wv;
        b_flat = {b1, b0};
    endtask

    task automatic set_exp(input logic [15:0] v);
        for (int i = 0; i < 8; i++) exp_d[i] = v;
    endtask

    // One full run of the default DUT; optional stall on output stall_idx and
    // start pokes while busy / during the done cycle.
    task automatic run(input string name, input int stall_idx, input bit poke, input int exp_done);
        int e, nget, first_v, done_e, stall;
        logic [15:0] got_d [8];
        logic [2:0]  got_i [8];
        e = 0; nget = 0; first_v = -1; done_e = -1; stall = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        in_flat = {16{$urandom()}};
        wt_flat = {8{$urandom()}};
        b_flat  = $urandom();
        relu_en = ~relu_en;
        chk({name, "_busy_start"}, busy, 1);
        while (done_e < 0 && e < 400) begin
            start     = 1'b0;
            out_ready = 1'b1;
            if (out_valid && first_v < 0) first_v = e;
            if (poke && e == 3) start = 1'b1;
            if (stall_idx >= 0 && out_valid && int'(out_index) == stall_idx && stall < 5) begin
                out_ready = 1'b0;
                chk({name, "_stall_idx"}, out_index, 3);
                chk({name, "_stall_data"}, out_data, exp_d[3]);
                stall++;
                if (poke && stall == 2) start = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (nget < 8) begin
                    got_d[nget] = out_data;
                    got_i[nget] = out_index;
                end
                nget++;
            end
            if (done) begin
                done_e = e;
                chk({name, "_valid_in_done"}, out_valid, 0);
                start = poke;
            end
            @(posedge clk); #1; e++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk({name, "_done_pulse"}, done, 0);
        chk({name, "_busy_end"}, busy, 0);
        @(posedge clk); #1;
        chk({name, "_idle_after"}, busy, 0);
        chk({name, "_first_valid"}, first_v, 8);
        chk({name, "_done_cycle"}, done_e, exp_done);
        chk({name, "_count"}, nget, 8);
        for (int i = 0; i < 8 && i < nget; i++) begin
            chk($sformatf("%s_data%0d", name, i), got_d[i], exp_d[i]);
            chk($sformatf("%s_idx%0d", name, i), got_i[i], i);
        end
    endtask

    initial begin
        int e, n, done_e, r, c;
        logic [15:0] pd [16];
        logic [3:0]  pi [16];

        #2 rst_n = 1'b0;
        #10;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_data", out_data, 0);
        chk("rst_index", out_index, 0);
        @(negedge clk) rst_n = 1'b1;

        fill(16'd1, 16'd1, 16'd0, 16'd0); set_exp(16'd8); relu_en = 1'b0;
        run("ones", -1, 1'b0, 72);

        fill(16'd1, 16'd1, 16'd5, 16'hFFFD); relu_en = 1'b0;
        for (int i = 0; i < 8; i++) exp_d[i] = (i < 4) ? 16'd13 : 16'd5;
        run("bias", -1, 1'b0, 72);

        fill(16'd0, 16'd0, 16'd0, 16'd0); relu_en = 1'b0;
        for (int h = 0; h < 4; h++)
            for (int w = 0; w < 4; w++) begin
                in_flat[(h*4+w)*16 +: 16]      = 16'(h*4 + w);
                in_flat[(16+h*4+w)*16 +: 16]   = 16'(100 + h*4 + w);
            end
        wt_flat[0*16 +: 16]  = 16'd1;
        wt_flat[15*16 +: 16] = 16'd1;
        exp_d[0] = 16'd0;   exp_d[1] = 16'd2;   exp_d[2] = 16'd8;   exp_d[3] = 16'd10;
        exp_d[4] = 16'd105; exp_d[5] = 16'd107; exp_d[6] = 16'd113; exp_d[7] = 16'd115;
        run("addr", -1, 1'b0, 72);

        fill(16'h7FFF, 16'h7FFF, 16'd0, 16'd0); set_exp(16'h7FFF); relu_en = 1'b0;
        run("satpos", -1, 1'b0, 72);
        fill(16'h7FFF, 16'h8000, 16'd0, 16'd0); set_exp(16'h8000); relu_en = 1'b0;
        run("satneg", -1, 1'b0, 72);

        fill(16'd1, 16'hFFFF, 16'd0, 16'd0); set_exp(16'hFFF8); relu_en = 1'b0;
        run("neg", -1, 1'b0, 72);
        fill(16'd1, 16'hFFFF, 16'd0, 16'd0); set_exp(16'h0000); relu_en = 1'b1;
        run("relu", -1, 1'b0, 72);

        fill(16'd1, 16'd1, 16'd0, 16'd0); set_exp(16'd8); relu_en = 1'b0;
        run("stall", 3, 1'b1, 77);

        // Reset in the middle of output 2's accumulation.
        fill(16'd1, 16'd1, 16'd0, 16'd0); relu_en = 1'b0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        chk("pre_rst_index", out_index, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_index", out_index, 0);
        @(negedge clk) rst_n = 1'b1;
        fill(16'd1, 16'd1, 16'd0, 16'd0); set_exp(16'd8); relu_en = 1'b0;
        run("after_rst", -1, 1'b0, 72);

        // Padded 3x3 stride-1 instance: ones in, ones weights.
        for (int i = 0; i < 16; i++) in_p[i*16 +: 16] = 16'd1;
        for (int i = 0; i < 9; i++)  wt_p[i*16 +: 16] = 16'd1;
        b_p = '0;
        e = 0; n = 0; done_e = -1;
        @(negedge clk); start_p = 1'b1;
        @(posedge clk); #1; start_p = 1'b0;
        while (done_e < 0 && e < 400) begin
            if (ov_p) begin
                if (n < 16) begin
                    pd[n] = od_p;
                    pi[n] = oi_p;
                end
                n++;
            end
            if (done_p) done_e = e;
            @(posedge clk); #1; e++;
        end
        chk("pad_done_cycle", done_e, 160);
        chk("pad_count", n, 16);
        for (int k = 0; k < 16 && k < n; k++) begin
            r = (k/4 == 0 || k/4 == 3) ? 2 : 3;
            c = (k%4 == 0 || k%4 == 3) ? 2 : 3;
            chk($sformatf("pad_data%0d", k), pd[k], r*c);
            chk($sformatf("pad_idx%0d", k), pi[k], k);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
